// File: rtl/sram32x64_req_ctrl.sv
// sram32x64_req_ctrl
//   Requester-side controller for one single-port SRAM macro with registered DO and no
//   byte enables. Turns a valid/ready request stream (reads and byte-strobed writes) into
//   SRAM CS/WE/A/DI cycles. Partial writes are done as read-modify-write. Read data returns
//   in request order through a 2-entry valid/ready response FIFO.
//
// Ports
//   clk, rst              clock (also the SRAM CK), synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_write             1 = write, 0 = read
//   req_addr/wdata/wstrb  word address, write data, byte strobes
//   rsp_valid/rsp_ready   read response handshake
//   rsp_rdata             read data (head of the response FIFO)
//   sram_cs/we/a/di       SRAM control, address and write data (combinational)
//   sram_do               SRAM read data, valid the cycle after a read cycle
module sram32x64_req_ctrl #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 64,
    localparam int unsigned SW = DW / 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic [SW-1:0] req_wstrb,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          sram_cs,
    output logic          sram_we,
    output logic [AW-1:0] sram_a,
    output logic [DW-1:0] sram_di,
    input  logic [DW-1:0] sram_do
);

    typedef enum logic [0:0] {StIdle, StRmw} state_e;

    state_e        state_q, state_d;
    logic          rd_pend_q, rd_pend_d;

    // Held copy of a partial write while its merge cycle runs.
    logic          latch_rmw;
    logic [AW-1:0] rmw_addr_q;
    logic [DW-1:0] rmw_wdata_q;
    logic [SW-1:0] rmw_wstrb_q;
    logic [DW-1:0] merge_data;

    // Response FIFO.
    logic [DW-1:0] fifo_mem_q [2];
    logic          fifo_wr_ptr_q;
    logic          fifo_rd_ptr_q;
    logic [1:0]    fifo_cnt_q, fifo_cnt_d;
    logic          push;
    logic          pop;

    logic [2:0]    credit_used;
    logic          accept;
    logic          wstrb_full;
    logic          wstrb_none;

    assign rsp_valid = (fifo_cnt_q != 2'd0);
    assign rsp_rdata = fifo_mem_q[fifo_rd_ptr_q];
    assign pop       = rsp_valid & rsp_ready;
    // The read issued last cycle lands in the FIFO this cycle.
    assign push      = rd_pend_q;

    // Every queued or in-flight read holds a FIFO slot; a slot freed by this cycle's pop
    // can be reused immediately, which is what sustains one read per cycle.
    assign credit_used = {1'b0, fifo_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
    assign req_ready   = !rst && (state_q == StIdle) && (credit_used < 3'd2);
    assign accept      = req_valid & req_ready;

    assign wstrb_full = &req_wstrb;
    assign wstrb_none = ~|req_wstrb;

    always_comb begin
        merge_data = '0;
        for (int i = 0; i < int'(SW); i++) begin
            merge_data[i*8 +: 8] = rmw_wstrb_q[i] ? rmw_wdata_q[i*8 +: 8] : sram_do[i*8 +: 8];
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_pend_d = 1'b0;
        latch_rmw = 1'b0;
        sram_cs   = 1'b0;
        sram_we   = 1'b0;
        sram_a    = '0;
        sram_di   = '0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (!req_write) begin
                        sram_cs   = 1'b1;
                        sram_a    = req_addr;
                        rd_pend_d = 1'b1;
                    end else if (wstrb_full) begin
                        sram_cs = 1'b1;
                        sram_we = 1'b1;
                        sram_a  = req_addr;
                        sram_di = req_wdata;
                    end else if (!wstrb_none) begin
                        // Read the old word now; merge and write it next cycle.
                        sram_cs   = 1'b1;
                        sram_a    = req_addr;
                        latch_rmw = 1'b1;
                        state_d   = StRmw;
                    end
                end
            end
            StRmw: begin
                sram_cs = 1'b1;
                sram_we = 1'b1;
                sram_a  = rmw_addr_q;
                sram_di = merge_data;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Reset during the merge cycle must not let the write reach the macro.
        if (rst) begin
            sram_cs = 1'b0;
            sram_we = 1'b0;
            sram_a  = '0;
            sram_di = '0;
        end
    end

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        unique case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            rd_pend_q     <= 1'b0;
            fifo_wr_ptr_q <= 1'b0;
            fifo_rd_ptr_q <= 1'b0;
            fifo_cnt_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            rd_pend_q  <= rd_pend_d;
            fifo_cnt_q <= fifo_cnt_d;
            if (push) begin
                fifo_wr_ptr_q <= ~fifo_wr_ptr_q;
            end
            if (pop) begin
                fifo_rd_ptr_q <= ~fifo_rd_ptr_q;
            end
        end
    end

    // Data-path registers need no reset; their contents are only used when qualified.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_mem_q[fifo_wr_ptr_q] <= sram_do;
        end
        if (latch_rmw) begin
            rmw_addr_q  <= req_addr;
            rmw_wdata_q <= req_wdata;
            rmw_wstrb_q <= req_wstrb;
        end
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (fifo_cnt_q == 2'd2)));

endmodule
